cdb_rr_arbiter: RTL and testbench

- Parametrised common data bus that takes completion results from NUM_FU functional units.
- Broadcasts up to SUPERSCALAR_WAY results per cycle: physical register tag plus result data.
- A 1-entry holding buffer per FU absorbs results that lose arbitration, with stall backpressure to that FU.
- Lanes are granted round-robin across cycles for fairness.
- Sits between the FU outputs and the RS wakeup, map-table and PRF-write logic.

---
 rtl/cdb_rr_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_cdb_rr_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_rr_arbiter
//
// Common data bus arbiter. It collects completion results from NUM_FU
// functional units and broadcasts up to SUPERSCALAR_WAY of them per cycle.
// Each broadcast carries a physical register tag and its result data.
//
// Each FU owns a one-entry holding buffer. A result that loses arbitration is
// parked in that buffer, and the FU is stalled until the parked result has
// been broadcast. Lanes are filled by scanning the FUs circularly, starting
// from a round-robin pointer. The pointer advances past the last FU that was
// granted, so every parked result is granted within
// ceil(NUM_FU/SUPERSCALAR_WAY) cycles.
//
// Ports
//   clk              clock; all state changes on the rising edge
//   reset            asynchronous reset, active low (0 = reset asserted)
//   flush_i          synchronous squash of all parked and in-flight results
//   FU_complete_i    [NUM_FU]            FU i presents a valid result
//   ready_reg_index  [NUM_FU][PREG_W]    destination physical register per FU
//   FU_data_i        [NUM_FU][DATA_W]    result value per FU
//   FU_stall_o       [NUM_FU]            FU i must hold its result; the new
//                                        result is not accepted this cycle
//   CDB_en_o         [WAY]               lane k carries a valid broadcast
//   CDB_o            [WAY][PREG_W]       broadcast tag per lane
//   CDB_data_o       [WAY][DATA_W]       broadcast data per lane
//
// Latency: a result accepted and granted in cycle t is on the bus for exactly
// one cycle, starting after edge t.
// -----------------------------------------------------------------------------
module cdb_rr_arbiter #(
    parameter int NUM_FU          = 5,
    parameter int SUPERSCALAR_WAY = 2,
    parameter int PHY_REG_NUM     = 8,
    parameter int DATA_W          = 32,
    localparam int PREG_W         = $clog2(PHY_REG_NUM)
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         flush_i,
    input  logic [NUM_FU-1:0]                            FU_complete_i,
    input  logic [NUM_FU-1:0][PREG_W-1:0]                ready_reg_index,
    input  logic [NUM_FU-1:0][DATA_W-1:0]                FU_data_i,
    output logic [NUM_FU-1:0]                            FU_stall_o,
    output logic [SUPERSCALAR_WAY-1:0]                   CDB_en_o,
    output logic [SUPERSCALAR_WAY-1:0][PREG_W-1:0]       CDB_o,
    output logic [SUPERSCALAR_WAY-1:0][DATA_W-1:0]       CDB_data_o
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    // Holding buffers, one entry per FU.
    logic [NUM_FU-1:0]                      pending_valid;
    logic [NUM_FU-1:0][PREG_W-1:0]          pending_tag;
    logic [NUM_FU-1:0][DATA_W-1:0]          pending_data;

    // The first FU index that the next scan looks at.
    logic [PTR_W-1:0]                       rr_ptr;

    // Candidate view, combinational.
    logic [NUM_FU-1:0]                      accept;
    logic [NUM_FU-1:0]                      cand;
    logic [NUM_FU-1:0][PREG_W-1:0]          cand_tag;
    logic [NUM_FU-1:0][DATA_W-1:0]          cand_data;

    // Selection results, combinational.
    logic [NUM_FU-1:0]                      grant;
    logic                                   any_grant;
    logic [PTR_W-1:0]                       rr_ptr_nxt;
    logic [SUPERSCALAR_WAY-1:0]             lane_en_nxt;
    logic [SUPERSCALAR_WAY-1:0][PREG_W-1:0] lane_tag_nxt;
    logic [SUPERSCALAR_WAY-1:0][DATA_W-1:0] lane_data_nxt;

    // Buffer update, combinational.
    logic [NUM_FU-1:0]                      pending_valid_nxt;
    logic [NUM_FU-1:0]                      capture;

    // The stall comes only from registered state. This keeps the path from
    // FU_complete_i back to the FU free of combinational logic.
    assign FU_stall_o = pending_valid;

    // -------------------------------------------------------------------------
    // Candidate set. A parked result wins over the live inputs. While an entry
    // is parked the FU is stalled, so its live result cannot be accepted in
    // the same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        accept = FU_complete_i & ~pending_valid;
        cand   = pending_valid | accept;
        for (int i = 0; i < NUM_FU; i++) begin
            cand_tag[i]  = pending_valid[i] ? pending_tag[i]  : ready_reg_index[i];
            cand_data[i] = pending_valid[i] ? pending_data[i] : FU_data_i[i];
        end
    end

    // -------------------------------------------------------------------------
    // Circular scan starting at rr_ptr. The scan runs in two passes over the
    // FU indices: the first pass covers rr_ptr..NUM_FU-1, the second covers
    // 0..rr_ptr-1. This gives the wrap-around order using constant indices
    // only. Lanes are filled in scan order.
    // -------------------------------------------------------------------------
    always_comb begin : select
        int lane_cnt;
        int last_idx;
        int rr_int;
        // NOTE: every variable driven here gets a default before any
        // conditional assignment, so no path leaves a value unassigned and
        // no latch can be inferred.
        grant         = '0;
        lane_en_nxt   = '0;
        lane_tag_nxt  = '0;
        lane_data_nxt = '0;
        lane_cnt      = 0;
        last_idx      = 0;
        rr_int        = int'(rr_ptr);

        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (((pass == 0) == (i >= rr_int)) && cand[i] &&
                    (lane_cnt < SUPERSCALAR_WAY)) begin
                    grant[i] = 1'b1;
                    for (int k = 0; k < SUPERSCALAR_WAY; k++) begin
                        if (k == lane_cnt) begin
                            lane_en_nxt[k]   = 1'b1;
                            lane_tag_nxt[k]  = cand_tag[i];
                            lane_data_nxt[k] = cand_data[i];
                        end
                    end
                    lane_cnt = lane_cnt + 1;
                    last_idx = i;
                end
            end
        end

        any_grant  = |grant;
        // The next scan starts just after the last FU that was granted.
        rr_ptr_nxt = (last_idx == NUM_FU - 1) ? '0 : PTR_W'(last_idx + 1);
    end

    // -------------------------------------------------------------------------
    // Buffer update. A granted candidate frees its entry. An accepted result
    // that was not granted gets parked.
    // -------------------------------------------------------------------------
    always_comb begin
        pending_valid_nxt = cand & ~grant;
        capture           = accept & ~grant;
    end

    // -------------------------------------------------------------------------
    // Control state and registered bus outputs. A flush takes priority over
    // every other update and drops anything presented in the same cycle.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples values from before the edge, whatever order the
    // blocks are evaluated in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_valid <= '0;
            rr_ptr        <= '0;
            CDB_en_o      <= '0;
            CDB_o         <= '0;
            CDB_data_o    <= '0;
        end else if (flush_i) begin
            pending_valid <= '0;
            rr_ptr        <= '0;
            CDB_en_o      <= '0;
            CDB_o         <= '0;
            CDB_data_o    <= '0;
        end else begin
            pending_valid <= pending_valid_nxt;
            CDB_en_o      <= lane_en_nxt;
            CDB_o         <= lane_tag_nxt;
            CDB_data_o    <= lane_data_nxt;
            if (any_grant) begin
                rr_ptr <= rr_ptr_nxt;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Holding-buffer payload. A flush does not need to touch the payload,
    // because clearing pending_valid already makes it invisible.
    // -------------------------------------------------------------------------
    // NOTE: the payload storage is reset as well, so a freshly reset block
    // never shows stale tags or data, even on paths that ignore the valid bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_tag  <= '0;
            pending_data <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (capture[i] && !flush_i) begin
                    pending_tag[i]  <= ready_reg_index[i];
                    pending_data[i] <= FU_data_i[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_rr_arbiter
//
// Self-checking bench for cdb_rr_arbiter. The reference model keeps, per FU,
// a parked flag with its tag and data, plus a round-robin start index. Each
// cycle it walks the FUs in the order (rr + off) % NUM_FU and fills the lanes
// in that order. Directed scenarios come first, then a randomized phase in
// which the FUs behave like real units: a stalled FU keeps presenting its
// result.
// -----------------------------------------------------------------------------
module tb_cdb_rr_arbiter;

    localparam int NUM_FU      = 5;
    localparam int WAY         = 2;
    localparam int PHY_REG_NUM = 8;
    localparam int PREG_W      = $clog2(PHY_REG_NUM);
    localparam int DATA_W      = 32;

    logic                              clk = 1'b0;
    logic                              reset;
    logic                              flush_i;
    logic [NUM_FU-1:0]                 FU_complete_i;
    logic [NUM_FU-1:0][PREG_W-1:0]     ready_reg_index;
    logic [NUM_FU-1:0][DATA_W-1:0]     FU_data_i;
    logic [NUM_FU-1:0]                 FU_stall_o;
    logic [WAY-1:0]                    CDB_en_o;
    logic [WAY-1:0][PREG_W-1:0]        CDB_o;
    logic [WAY-1:0][DATA_W-1:0]        CDB_data_o;

    cdb_rr_arbiter #(
        .NUM_FU          (NUM_FU),
        .SUPERSCALAR_WAY (WAY),
        .PHY_REG_NUM     (PHY_REG_NUM),
        .DATA_W          (DATA_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .flush_i         (flush_i),
        .FU_complete_i   (FU_complete_i),
        .ready_reg_index (ready_reg_index),
        .FU_data_i       (FU_data_i),
        .FU_stall_o      (FU_stall_o),
        .CDB_en_o        (CDB_en_o),
        .CDB_o           (CDB_o),
        .CDB_data_o      (CDB_data_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: the contents of the holding buffers after the
    // most recent edge.
    bit                  m_pv [NUM_FU];
    logic [PREG_W-1:0]   m_pt [NUM_FU];
    logic [DATA_W-1:0]   m_pd [NUM_FU];
    int                  m_rr;

    // Bus contents the model expects after the next edge.
    logic [WAY-1:0]              e_en;
    logic [WAY-1:0][PREG_W-1:0]  e_tag;
    logic [WAY-1:0][DATA_W-1:0]  e_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NUM_FU-1:0] pend_mask();
        logic [NUM_FU-1:0] m;
        for (int i = 0; i < NUM_FU; i++) m[i] = m_pv[i];
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_FU; i++) begin
            m_pv[i] = 1'b0;
            m_pt[i] = '0;
            m_pd[i] = '0;
        end
        m_rr = 0;
    endtask

    // Advance the model across one clock edge, using the inputs driven now.
    task automatic model_edge(input logic [NUM_FU-1:0] comp, input logic fl);
        logic [NUM_FU-1:0] acc;
        bit                granted [NUM_FU];
        int                lane;
        int                last;
        e_en   = '0;
        e_tag  = '0;
        e_data = '0;
        if (fl) begin
            for (int i = 0; i < NUM_FU; i++) m_pv[i] = 1'b0;
            m_rr = 0;
            return;
        end
        acc  = comp & ~pend_mask();
        lane = 0;
        last = -1;
        for (int i = 0; i < NUM_FU; i++) granted[i] = 1'b0;
        for (int off = 0; off < NUM_FU; off++) begin
            int i;
            i = (m_rr + off) % NUM_FU;
            if ((m_pv[i] || acc[i]) && lane < WAY) begin
                e_en[lane]   = 1'b1;
                e_tag[lane]  = m_pv[i] ? m_pt[i] : ready_reg_index[i];
                e_data[lane] = m_pv[i] ? m_pd[i] : FU_data_i[i];
                granted[i]   = 1'b1;
                lane++;
                last = i;
            end
        end
        for (int i = 0; i < NUM_FU; i++) begin
            if (granted[i]) begin
                m_pv[i] = 1'b0;
            end else if (acc[i]) begin
                m_pv[i] = 1'b1;
                m_pt[i] = ready_reg_index[i];
                m_pd[i] = FU_data_i[i];
            end
        end
        if (last >= 0) m_rr = (last + 1) % NUM_FU;
    endtask

    // One cycle. The caller is at a falling edge and has already set the tags
    // and data. The task returns at the next falling edge, with the outputs of
    // this cycle's edge still on the bus.
    task automatic step(input logic [NUM_FU-1:0] comp, input logic fl);
        FU_complete_i = comp;
        flush_i       = fl;
        #1;
        check("stall", 64'(FU_stall_o), 64'(pend_mask()));
        model_edge(comp, fl);
        @(posedge clk);
        #1;
        check("cdb_en",   64'(CDB_en_o),   64'(e_en));
        check("cdb_tag",  64'(CDB_o),      64'(e_tag));
        check("cdb_data", 64'(CDB_data_o), 64'(e_data));
        @(negedge clk);
    endtask

    task automatic set_fu(input int i, input logic [PREG_W-1:0] t, input logic [DATA_W-1:0] d);
        ready_reg_index[i] = t;
        FU_data_i[i]       = d;
    endtask

    logic              h_on   [NUM_FU];
    logic [PREG_W-1:0] h_tag  [NUM_FU];
    logic [DATA_W-1:0] h_data [NUM_FU];

    initial begin
        reset           = 1'b0;
        flush_i         = 1'b0;
        FU_complete_i   = '1;
        ready_reg_index = '0;
        FU_data_i       = '0;
        for (int i = 0; i < NUM_FU; i++) set_fu(i, PREG_W'(i + 1), 32'hDEAD_0000 + 32'(i));
        model_reset();

        // Reset held low while every FU completes: the bus stays quiet.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_en",    64'(CDB_en_o),   64'd0);
            check("rst_tag",   64'(CDB_o),      64'd0);
            check("rst_data",  64'(CDB_data_o), 64'd0);
            check("rst_stall", 64'(FU_stall_o), 64'd0);
        end
        FU_complete_i = '0;
        reset         = 1'b1;
        step('0, 1'b0);
        step('0, 1'b0);

        // A single completion is broadcast once, one cycle later.
        set_fu(0, 3'b010, 32'hA5);
        step(5'b00001, 1'b0);
        check("single_en",   64'(CDB_en_o),      64'b01);
        check("single_tag",  64'(CDB_o[0]),      64'b010);
        check("single_data", 64'(CDB_data_o[0]), 64'hA5);
        step('0, 1'b0);
        check("single_after_en", 64'(CDB_en_o), 64'd0);

        // Two completions from rr_ptr = 0; the flush step zeroes the pointer.
        step('0, 1'b1);
        set_fu(0, 3'b101, 32'h1111);
        set_fu(1, 3'b001, 32'h2222);
        step(5'b00011, 1'b0);
        check("two_en",    64'(CDB_en_o),   64'b11);
        check("two_tag",   64'(CDB_o),      64'({3'b001, 3'b101}));
        check("two_stall", 64'(FU_stall_o), 64'd0);

        // Oversubscription: all five FUs complete at once.
        step('0, 1'b1);
        for (int i = 0; i < NUM_FU; i++) set_fu(i, PREG_W'(i + 1), 32'h100 + 32'(i));
        step(5'b11111, 1'b0);
        check("over1_tag",   64'(CDB_o),      64'({3'd2, 3'd1}));
        check("over1_stall", 64'(FU_stall_o), 64'b11100);
        step('0, 1'b0);
        check("over2_tag",   64'(CDB_o),      64'({3'd4, 3'd3}));
        check("over2_stall", 64'(FU_stall_o), 64'b10000);
        step('0, 1'b0);
        check("over3_en",    64'(CDB_en_o),   64'b01);
        check("over3_tag",   64'(CDB_o[0]),   64'd5);
        check("over3_stall", 64'(FU_stall_o), 64'd0);

        // Fairness: FU0, FU1 and FU4 complete every cycle, tag = FU index.
        for (int i = 0; i < NUM_FU; i++) set_fu(i, PREG_W'(i), 32'h200 + 32'(i));
        step(5'b10011, 1'b0);
        check("rr1_tag", 64'(CDB_o), 64'({3'd1, 3'd0}));
        step(5'b10011, 1'b0);
        check("rr2_tag", 64'(CDB_o), 64'({3'd0, 3'd4}));
        step(5'b10011, 1'b0);
        check("rr3_tag", 64'(CDB_o), 64'({3'd4, 3'd1}));
        for (int c = 0; c < 6; c++) step(5'b10011, 1'b0);

        // Flush with three entries parked, while FU0 and FU1 present results.
        step('0, 1'b1);
        for (int i = 0; i < NUM_FU; i++) set_fu(i, PREG_W'(i + 1), 32'h300 + 32'(i));
        step(5'b11111, 1'b0);
        set_fu(0, 3'd6, 32'hF0F0);
        set_fu(1, 3'd7, 32'hF1F1);
        step(5'b00011, 1'b1);
        check("flush_en",    64'(CDB_en_o),   64'd0);
        check("flush_stall", 64'(FU_stall_o), 64'd0);
        step('0, 1'b0);
        check("flush_after_en", 64'(CDB_en_o), 64'd0);

        // Asynchronous reset in mid-cycle with two entries parked.
        for (int i = 0; i < NUM_FU; i++) set_fu(i, PREG_W'(i + 1), 32'h400 + 32'(i));
        step(5'b11110, 1'b0);
        check("arst_pre_stall", 64'(FU_stall_o), 64'b11000);
        FU_complete_i = '0;
        #2;
        reset = 1'b0;
        #1;
        check("arst_en",    64'(CDB_en_o),   64'd0);
        check("arst_tag",   64'(CDB_o),      64'd0);
        check("arst_data",  64'(CDB_data_o), 64'd0);
        check("arst_stall", 64'(FU_stall_o), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step('0, 1'b0);

        // Randomized traffic. A stalled FU keeps presenting the same result.
        for (int i = 0; i < NUM_FU; i++) h_on[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic [NUM_FU-1:0] comp;
            for (int i = 0; i < NUM_FU; i++) begin
                if (!(h_on[i] && m_pv[i])) begin
                    h_on[i]   = ($urandom_range(0, 99) < 60);
                    h_tag[i]  = PREG_W'($urandom);
                    h_data[i] = $urandom;
                end
                comp[i] = h_on[i];
                set_fu(i, h_tag[i], h_data[i]);
            end
            step(comp, ($urandom_range(0, 31) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
